glb_bank_req_arbiter: RTL and testbench
=======================================

// Module: glb_bank_req_arbiter
// PURPOSE
// Upstream of the bank controller. Merges packet read/write requests from two
// requesters (port 0: processor path, port 1: stream path) into the controller's
// single packet write/read interface. Issues at most one op per cycle and
// withholds issue while SRAM-config traffic owns the bank. Tags in-flight reads
// and routes each returned read word to the requester that issued it.
// PARAMETERS
// BANK_ADDR_WIDTH  17  bank byte-address width
// BANK_DATA_WIDTH  64  bank word width
// FIFO_DEPTH       2   request FIFO entries per port (power of 2, >=2)
// RD_LATENCY       3   cycles from packet_rd_en to packet_rd_data_valid
// PORTS
// clk                   in   1        clock
// reset                 in   1        reset, asynchronous, active-high
// req_valid             in   2        per-port request valid
// req_ready             out  2        per-port request ready (FIFO not full)
// req_wr                in   2        per-port op: 1=write, 0=read
// req_addr              in   2xBAW    per-port address
// req_data              in   2xBDW    per-port write data
// req_bit_sel           in   2xBDW    per-port write bit enables
// resp_valid            out  2        per-port read response pulse
// resp_data             out  2xBDW    per-port read response data
// cfg_busy              in   1        SRAM-config wr_en|rd_en this cycle
// packet_wr_en          out  1        to bank ctrl
// packet_wr_addr        out  BAW      to bank ctrl
// packet_wr_data        out  BDW      to bank ctrl
// packet_wr_data_bit_sel out BDW      to bank ctrl
// packet_rd_en          out  1        to bank ctrl
// packet_rd_addr        out  BAW      to bank ctrl
// packet_rd_data        in   BDW      from bank ctrl
// packet_rd_data_valid  in   1        from bank ctrl
// err_resp_mismatch     out  1        sticky: response/tag disagreement
// BEHAVIOUR
// - Reset: FIFOs empty, req_ready=2'b11, rr_ptr=0, tag pipe cleared, all
//   packet_* outputs 0, resp_valid=0, resp_data=0, err_resp_mismatch=0.
// - Push: req_valid[i]&req_ready[i]. req_ready[i]=!full[i] from registered count;
//   no same-cycle pop credit. Counts are log2(FIFO_DEPTH)+1 bits, pointers wrap.
// - Issue (combinational from FIFO heads): if cfg_busy=1 nothing issues, all
//   packet_* enables 0. Else grant among non-empty FIFOs: both non-empty ->
//   port rr_ptr; one non-empty -> that port. Granted head pops same cycle.
// - Granted write: packet_wr_en=1 with addr/data/bit_sel; packet_rd_en=0.
//   Granted read: packet_rd_en=1, packet_rd_addr; packet_wr_en=0. Never both.
//   Idle: enables 0, addr/data/bit_sel driven 0.
// - rr_ptr updates only on a grant: rr_ptr <= ~granted_port.
// - Tag pipe: RD_LATENCY-stage shift reg of {valid,port}; stage0 = {rd issued,
//   granted port}. At final stage: tag valid & packet_rd_data_valid ->
//   resp_valid[port]=1, resp_data[port]=packet_rd_data (combinational, 1 cycle);
//   resp_data holds last value otherwise. No response backpressure.
// - Mismatch (tag valid xor packet_rd_data_valid) -> err_resp_mismatch set,
//   held until reset; a stray valid produces no resp_valid.
// - Simultaneous push to empty FIFO and cfg_busy=0: entry issues next cycle
//   (no FIFO bypass). Push and pop on same FIFO same cycle: count unchanged.
// - Reset mid-operation: queued requests and in-flight tags discarded; no
//   resp_valid for reads issued before reset.
// TESTING
// 1 p0 write addr=0x10 data=0xDEAD bit_sel=all1 -> next cycle packet_wr_en=1,
//   addr 0x10, data 0xDEAD, packet_rd_en=0 that cycle.
// 2 p1 read 0x20; model returns 0x1234 with valid 3 cycles after rd_en ->
//   resp_valid[1]=1, resp_data[1]=0x1234 that cycle, resp_valid[0]=0.
// 3 both ports stream reads (p0 0x0,0x8.., p1 0x100,0x108..) -> grants 0,1,0,1;
//   responses return to matching port in issue order.
// 4 cfg_busy=1 for 4 cycles, p0 pushes 3 reads -> no packet enables, req_ready[0]
//   low after 2 pushes; issue resumes the cycle cfg_busy drops.
// 5 reset asserted 1 cycle after p0 read issue -> resp_valid stays 0, rr_ptr=0,
//   req_ready=2'b11.
// 6 packet_rd_data_valid pulsed with no read issued -> err_resp_mismatch=1 sticky,
//   resp_valid=0.

Source files
------------

// File: rtl/glb_bank_req_arbiter.sv
// Two-port packet request arbiter in front of the bank controller.
// Per-port request FIFOs, round-robin issue gated by SRAM-config traffic, and tagged read-response routing.
module glb_bank_req_arbiter #(
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH      = 2,
    parameter int RD_LATENCY      = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_wr,
    input  logic [1:0][BANK_ADDR_WIDTH-1:0]      req_addr,
    input  logic [1:0][BANK_DATA_WIDTH-1:0]      req_data,
    input  logic [1:0][BANK_DATA_WIDTH-1:0]      req_bit_sel,
    output logic [1:0]                           resp_valid,
    output logic [1:0][BANK_DATA_WIDTH-1:0]      resp_data,
    input  logic                                 cfg_busy,
    output logic                                 packet_wr_en,
    output logic [BANK_ADDR_WIDTH-1:0]           packet_wr_addr,
    output logic [BANK_DATA_WIDTH-1:0]           packet_wr_data,
    output logic [BANK_DATA_WIDTH-1:0]           packet_wr_data_bit_sel,
    output logic                                 packet_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]           packet_rd_addr,
    input  logic [BANK_DATA_WIDTH-1:0]           packet_rd_data,
    input  logic                                 packet_rd_data_valid,
    output logic                                 err_resp_mismatch
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic                       fifo_wr      [2][FIFO_DEPTH];
    logic [BANK_ADDR_WIDTH-1:0] fifo_addr    [2][FIFO_DEPTH];
    logic [BANK_DATA_WIDTH-1:0] fifo_data    [2][FIFO_DEPTH];
    logic [BANK_DATA_WIDTH-1:0] fifo_bit_sel [2][FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] count  [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] nonempty;
    logic       grant_valid;
    logic       grant_port;
    logic       rr_ptr;

    logic [RD_LATENCY-1:0] tag_valid;
    logic [RD_LATENCY-1:0] tag_port;
    logic                  fin_valid;
    logic                  fin_port;

    logic [1:0][BANK_DATA_WIDTH-1:0] resp_hold;

    // Readiness comes only from the registered count, so a pop never frees a slot in the same cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req_ready[p] = (count[p] != DEPTH_C);
            nonempty[p]  = (count[p] != '0);
            push[p]      = req_valid[p] & (count[p] != DEPTH_C);
        end
    end

    always_comb begin
        grant_valid = !cfg_busy && (nonempty != 2'b00);
        grant_port  = (nonempty == 2'b11) ? rr_ptr : nonempty[1];
        pop[0]      = grant_valid && !grant_port;
        pop[1]      = grant_valid && grant_port;
    end

    always_comb begin
        packet_wr_en           = 1'b0;
        packet_wr_addr         = '0;
        packet_wr_data         = '0;
        packet_wr_data_bit_sel = '0;
        packet_rd_en           = 1'b0;
        packet_rd_addr         = '0;
        if (grant_valid) begin
            if (fifo_wr[grant_port][rd_ptr[grant_port]]) begin
                packet_wr_en           = 1'b1;
                packet_wr_addr         = fifo_addr[grant_port][rd_ptr[grant_port]];
                packet_wr_data         = fifo_data[grant_port][rd_ptr[grant_port]];
                packet_wr_data_bit_sel = fifo_bit_sel[grant_port][rd_ptr[grant_port]];
            end else begin
                packet_rd_en   = 1'b1;
                packet_rd_addr = fifo_addr[grant_port][rd_ptr[grant_port]];
            end
        end
    end

    // Payload storage carries no reset; validity is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_wr[p][wr_ptr[p]]      <= req_wr[p];
                fifo_addr[p][wr_ptr[p]]    <= req_addr[p];
                fifo_data[p][wr_ptr[p]]    <= req_data[p];
                fifo_bit_sel[p][wr_ptr[p]] <= req_bit_sel[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
            rr_ptr <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push[p] && !pop[p])      count[p] <= count[p] + 1'b1;
                else if (!push[p] && pop[p]) count[p] <= count[p] - 1'b1;
            end
            if (grant_valid) rr_ptr <= ~grant_port;
        end
    end

    // The tag pipe mirrors the bank read latency so the final stage lines up with returned data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid[0] <= packet_rd_en;
            tag_port[0]  <= grant_port;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_port[k]  <= tag_port[k-1];
            end
        end
    end

    assign fin_valid = tag_valid[RD_LATENCY-1];
    assign fin_port  = tag_port[RD_LATENCY-1];

    always_comb begin
        resp_valid = 2'b00;
        resp_data  = resp_hold;
        if (fin_valid && packet_rd_data_valid) begin
            resp_valid[fin_port] = 1'b1;
            resp_data[fin_port]  = packet_rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_hold         <= '0;
            err_resp_mismatch <= 1'b0;
        end else begin
            resp_hold <= resp_data;
            if (fin_valid ^ packet_rd_data_valid) err_resp_mismatch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glb_bank_req_arbiter.sv
// Scoreboard bench for glb_bank_req_arbiter: directed requests push expected issues/responses,
// a forked monitor pops and compares whenever the DUT issues or responds.
module tb_glb_bank_req_arbiter;

    localparam int BAW   = 17;
    localparam int BDW   = 64;
    localparam int DEPTH = 2;
    localparam int LAT   = 3;

    typedef struct {
        logic           wr;
        logic [BAW-1:0] addr;
        logic [BDW-1:0] data;
        logic [BDW-1:0] bs;
    } issue_t;

    logic clk = 1'b0;
    logic reset;
    logic cfg_busy;
    logic stray;

    logic           tb_valid [2];
    logic           tb_wr    [2];
    logic [BAW-1:0] tb_addr  [2];
    logic [BDW-1:0] tb_data  [2];
    logic [BDW-1:0] tb_bs    [2];

    logic [1:0]           req_valid, req_ready, req_wr, resp_valid;
    logic [1:0][BAW-1:0]  req_addr;
    logic [1:0][BDW-1:0]  req_data, req_bit_sel, resp_data;
    logic                 packet_wr_en, packet_rd_en, packet_rd_data_valid, err_resp_mismatch;
    logic [BAW-1:0]       packet_wr_addr, packet_rd_addr;
    logic [BDW-1:0]       packet_wr_data, packet_wr_data_bit_sel, packet_rd_data;

    issue_t         exp_issue [$];
    logic [BDW-1:0] exp_resp0 [$];
    logic [BDW-1:0] exp_resp1 [$];

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    assign req_valid   = {tb_valid[1], tb_valid[0]};
    assign req_wr      = {tb_wr[1], tb_wr[0]};
    assign req_addr    = {tb_addr[1], tb_addr[0]};
    assign req_data    = {tb_data[1], tb_data[0]};
    assign req_bit_sel = {tb_bs[1], tb_bs[0]};

    glb_bank_req_arbiter #(
        .BANK_ADDR_WIDTH(BAW), .BANK_DATA_WIDTH(BDW), .FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_bit_sel(req_bit_sel),
        .resp_valid(resp_valid), .resp_data(resp_data), .cfg_busy(cfg_busy),
        .packet_wr_en(packet_wr_en), .packet_wr_addr(packet_wr_addr),
        .packet_wr_data(packet_wr_data), .packet_wr_data_bit_sel(packet_wr_data_bit_sel),
        .packet_rd_en(packet_rd_en), .packet_rd_addr(packet_rd_addr),
        .packet_rd_data(packet_rd_data), .packet_rd_data_valid(packet_rd_data_valid),
        .err_resp_mismatch(err_resp_mismatch)
    );

    // Bank controller model: read data returns LAT cycles after packet_rd_en, sampled mid-cycle.
    function automatic logic [BDW-1:0] bank_data(logic [BAW-1:0] a);
        return (a == 17'h20) ? 64'h1234 : (64'hC0DE_0000 | 64'(a));
    endfunction

    logic           rd_seen;
    logic [BAW-1:0] rd_seen_addr;
    logic [LAT-1:0] bank_v;
    logic [BDW-1:0] bank_d [LAT];

    always @(negedge clk) begin
        rd_seen      <= packet_rd_en;
        rd_seen_addr <= packet_rd_addr;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_v <= '0;
            for (int k = 0; k < LAT; k++) bank_d[k] <= '0;
        end else begin
            bank_v    <= {bank_v[LAT-2:0], rd_seen};
            bank_d[0] <= bank_data(rd_seen_addr);
            for (int k = 1; k < LAT; k++) bank_d[k] <= bank_d[k-1];
        end
    end

    assign packet_rd_data_valid = bank_v[LAT-1] | stray;
    assign packet_rd_data       = bank_d[LAT-1];

    function automatic issue_t mk_issue(logic wr, logic [BAW-1:0] a, logic [BDW-1:0] d, logic [BDW-1:0] bs);
        issue_t e;
        e.wr = wr; e.addr = a; e.data = d; e.bs = bs;
        return e;
    endfunction

    task automatic check_output(string name, logic [BDW-1:0] act, logic [BDW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_unexpected(string name);
        n_checks++;
        n_bad++;
        $display("[TB] FAIL %s: got event expected none at %0t", name, $time);
    endtask

    task automatic monitor_loop();
        issue_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cfg_busy) check_output("cfg_busy_quiet", 64'({packet_wr_en, packet_rd_en}), 64'd0);
                if (packet_wr_en || packet_rd_en) begin
                    if (exp_issue.size() == 0) report_unexpected("unexpected_issue");
                    else begin
                        e = exp_issue.pop_front();
                        check_output("issue_kind", 64'({packet_wr_en, packet_rd_en}), e.wr ? 64'd2 : 64'd1);
                        if (e.wr) begin
                            check_output("wr_addr", 64'(packet_wr_addr), 64'(e.addr));
                            check_output("wr_data", packet_wr_data, e.data);
                            check_output("wr_bit_sel", packet_wr_data_bit_sel, e.bs);
                        end else begin
                            check_output("rd_addr", 64'(packet_rd_addr), 64'(e.addr));
                        end
                    end
                end else begin
                    check_output("idle_zero", packet_wr_data | packet_wr_data_bit_sel |
                                 64'(packet_wr_addr) | 64'(packet_rd_addr), 64'd0);
                end
                if (resp_valid[0]) begin
                    if (exp_resp0.size() == 0) report_unexpected("unexpected_resp0");
                    else check_output("resp_data0", resp_data[0], exp_resp0.pop_front());
                end
                if (resp_valid[1]) begin
                    if (exp_resp1.size() == 0) report_unexpected("unexpected_resp1");
                    else check_output("resp_data1", resp_data[1], exp_resp1.pop_front());
                end
            end
        end
    endtask

    // Presents one request and holds it until a clock edge where req_ready was high.
    task automatic apply_stimulus(int p, logic wr, logic [BAW-1:0] a, logic [BDW-1:0] d, logic [BDW-1:0] bs);
        bit done;
        done = 1'b0;
        tb_valid[p] = 1'b1; tb_wr[p] = wr; tb_addr[p] = a; tb_data[p] = d; tb_bs[p] = bs;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            done = req_ready[p];
            @(posedge clk);
            #1;
        end
        tb_valid[p] = 1'b0; tb_wr[p] = 1'b0; tb_addr[p] = '0; tb_data[p] = '0; tb_bs[p] = '0;
        check_output("push_accept", 64'(done), 64'd1);
    endtask

    task automatic wait_drain(int budget);
        int c;
        c = 0;
        while ((exp_issue.size() + exp_resp0.size() + exp_resp1.size()) != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_output("drain", 64'(exp_issue.size() + exp_resp0.size() + exp_resp1.size()), 64'd0);
    endtask

    logic [BAW-1:0] a_addr [4] = '{17'h0, 17'h8, 17'h10, 17'h18};
    logic [BAW-1:0] b_addr [4] = '{17'h100, 17'h108, 17'h110, 17'h118};
    logic [BDW-1:0] a_resp [4] = '{64'hC0DE_0000, 64'hC0DE_0008, 64'hC0DE_0010, 64'hC0DE_0018};
    logic [BDW-1:0] b_resp [4] = '{64'hC0DE_0100, 64'hC0DE_0108, 64'hC0DE_0110, 64'hC0DE_0118};

    initial begin
        for (int p = 0; p < 2; p++) begin
            tb_valid[p] = 1'b0; tb_wr[p] = 1'b0; tb_addr[p] = '0; tb_data[p] = '0; tb_bs[p] = '0;
        end
        cfg_busy = 1'b0;
        stray    = 1'b0;
        reset    = 1'b1;
        fork
            monitor_loop();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd3);
        check_output("rst_enables", 64'({packet_wr_en, packet_rd_en}), 64'd0);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_resp_data", resp_data[0] | resp_data[1], 64'd0);
        check_output("rst_err", 64'(err_resp_mismatch), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] single write on port 0");
        exp_issue.push_back(mk_issue(1'b1, 17'h10, 64'hDEAD, '1));
        apply_stimulus(0, 1'b1, 17'h10, 64'hDEAD, '1);
        @(negedge clk);
        check_output("t1_wr_next_cycle", 64'({packet_wr_en, packet_rd_en}), 64'd2);
        wait_drain(10);

        $display("[TB] single read on port 1");
        exp_issue.push_back(mk_issue(1'b0, 17'h20, '0, '0));
        exp_resp1.push_back(64'h1234);
        apply_stimulus(1, 1'b0, 17'h20, '0, '0);
        wait_drain(20);

        $display("[TB] interleaved read streams");
        for (int i = 0; i < 4; i++) begin
            exp_issue.push_back(mk_issue(1'b0, a_addr[i], '0, '0));
            exp_issue.push_back(mk_issue(1'b0, b_addr[i], '0, '0));
            exp_resp0.push_back(a_resp[i]);
            exp_resp1.push_back(b_resp[i]);
        end
        fork
            for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, a_addr[i], '0, '0);
            for (int j = 0; j < 4; j++) apply_stimulus(1, 1'b0, b_addr[j], '0, '0);
        join
        wait_drain(40);

        $display("[TB] cfg_busy blocks issue");
        exp_issue.push_back(mk_issue(1'b0, 17'h200, '0, '0));
        exp_issue.push_back(mk_issue(1'b0, 17'h208, '0, '0));
        exp_issue.push_back(mk_issue(1'b0, 17'h210, '0, '0));
        exp_resp0.push_back(64'hC0DE_0200);
        exp_resp0.push_back(64'hC0DE_0208);
        exp_resp0.push_back(64'hC0DE_0210);
        fork
            begin
                apply_stimulus(0, 1'b0, 17'h200, '0, '0);
                apply_stimulus(0, 1'b0, 17'h208, '0, '0);
                apply_stimulus(0, 1'b0, 17'h210, '0, '0);
            end
            begin
                cfg_busy = 1'b1;
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                check_output("t4_ready_low", 64'(req_ready[0]), 64'd0);
                @(posedge clk);
                @(posedge clk);
                #1 cfg_busy = 1'b0;
                @(negedge clk);
                check_output("t4_resume", 64'(packet_rd_en), 64'd1);
            end
        join
        wait_drain(30);

        $display("[TB] reset during in-flight read");
        exp_issue.push_back(mk_issue(1'b0, 17'h40, '0, '0));
        apply_stimulus(0, 1'b0, 17'h40, '0, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("t5_ready_in_reset", 64'(req_ready), 64'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_output("t5_err_clear", 64'(err_resp_mismatch), 64'd0);
        exp_issue.push_back(mk_issue(1'b0, 17'h50, '0, '0));
        exp_issue.push_back(mk_issue(1'b0, 17'h150, '0, '0));
        exp_resp0.push_back(64'hC0DE_0050);
        exp_resp1.push_back(64'hC0DE_0150);
        fork
            apply_stimulus(0, 1'b0, 17'h50, '0, '0);
            apply_stimulus(1, 1'b0, 17'h150, '0, '0);
        join
        wait_drain(20);

        $display("[TB] stray read data valid");
        stray = 1'b1;
        @(negedge clk);
        check_output("t6_no_resp", 64'(resp_valid), 64'd0);
        check_output("t6_hold0", resp_data[0], 64'hC0DE_0050);
        check_output("t6_hold1", resp_data[1], 64'hC0DE_0150);
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        check_output("t6_err_set", 64'(err_resp_mismatch), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("t6_err_sticky", 64'(err_resp_mismatch), 64'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
